// File: rtl/ins_prefetch_unit.sv
//------------------------------------------------------------------------------
// Module   : ins_prefetch_unit
// Purpose  : Instruction fetch stage with a prefetch queue and redirect/flush.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ins_prefetch_unit #(
    parameter int                   BUS_WIDTH    = 32,
    parameter logic [BUS_WIDTH-1:0] PC_INCREMENT = BUS_WIDTH'(1),
    parameter int                   QUEUE_DEPTH  = 4,
    parameter logic [BUS_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         redirect_in,
    input  logic [BUS_WIDTH-1:0]         redirect_pc_in,
    input  logic                         freeze_pc_in,
    output logic                         imem_req_out,
    output logic [BUS_WIDTH-1:0]         imem_addr_out,
    input  logic                         imem_valid_in,
    input  logic [BUS_WIDTH-1:0]         imem_data_in,
    output logic                         ins_valid_out,
    input  logic                         ins_ready_in,
    output logic [BUS_WIDTH-1:0]         ins_out,
    output logic [BUS_WIDTH-1:0]         npc_out,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count_out
);

    localparam int          PW      = $clog2(QUEUE_DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(QUEUE_DEPTH);

    logic [BUS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [BUS_WIDTH-1:0] q_data_q [QUEUE_DEPTH];
    logic [BUS_WIDTH-1:0] q_npc_q  [QUEUE_DEPTH];
    logic [BUS_WIDTH-1:0] fl_addr_q[QUEUE_DEPTH];
    logic [PW-1:0]        q_rd_q, q_wr_q, fl_rd_q, fl_wr_q;
    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        outst_q, outst_d;
    logic [CW-1:0]        discard_q, discard_d;

    logic issue, push, pop, head_valid;

    // Credit counts both queued words and words still in flight, so a push never overflows.
    assign issue      = !reset && !freeze_pc_in && !redirect_in
                        && (({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_C);
    assign head_valid = (count_q != '0);
    assign push       = imem_valid_in && (discard_q == '0) && !redirect_in;
    assign pop        = head_valid && ins_ready_in && !redirect_in;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_in) begin
            fetch_pc_d = redirect_pc_in;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + PC_INCREMENT;
        end

        count_d = count_q + CW'(push) - CW'(pop);
        if (redirect_in) begin
            count_d = '0;
        end

        outst_d = outst_q + CW'(issue) - CW'(imem_valid_in);

        // The response arriving in the redirect cycle is already dropped, so it is not counted.
        discard_d = discard_q;
        if (redirect_in) begin
            discard_d = outst_q - CW'(imem_valid_in);
        end else if (imem_valid_in && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            q_rd_q     <= '0;
            q_wr_q     <= '0;
            fl_rd_q    <= '0;
            fl_wr_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            if (issue) begin
                fl_wr_q <= fl_wr_q + PW'(1);
            end
            if (imem_valid_in) begin
                fl_rd_q <= fl_rd_q + PW'(1);
            end
            if (redirect_in) begin
                q_rd_q <= '0;
                q_wr_q <= '0;
            end else begin
                if (push) begin
                    q_wr_q <= q_wr_q + PW'(1);
                end
                if (pop) begin
                    q_rd_q <= q_rd_q + PW'(1);
                end
            end
        end
    end

    // Storage needs no reset: occupancy and pointers decide what is visible.
    always_ff @(posedge clock) begin
        if (issue) begin
            fl_addr_q[fl_wr_q] <= fetch_pc_q;
        end
        if (push && !reset) begin
            q_data_q[q_wr_q] <= imem_data_in;
            q_npc_q[q_wr_q]  <= fl_addr_q[fl_rd_q] + PC_INCREMENT;
        end
    end

    assign imem_req_out    = issue;
    assign imem_addr_out   = reset ? '0 : fetch_pc_q;
    assign ins_valid_out   = !reset && head_valid;
    assign ins_out         = ins_valid_out ? q_data_q[q_rd_q] : '0;
    assign npc_out         = ins_valid_out ? q_npc_q[q_rd_q]  : '0;
    assign queue_count_out = reset ? '0 : count_q;

endmodule

`default_nettype wire

// File: tb/tb_ins_prefetch_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_ins_prefetch_unit
// Purpose  : Directed bench for ins_prefetch_unit with a fixed-latency memory.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ins_prefetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        freeze_pc_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_valid_in;
    logic [31:0] imem_data_in;
    logic        ins_valid_out;
    logic        ins_ready_in;
    logic [31:0] ins_out;
    logic [31:0] npc_out;
    logic [2:0]  queue_count_out;

    always #5 clock = ~clock;

    ins_prefetch_unit #(
        .BUS_WIDTH   (32),
        .PC_INCREMENT(32'd1),
        .QUEUE_DEPTH (4),
        .RESET_PC    (32'hFFFF_FFFE)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_in    (redirect_in),
        .redirect_pc_in (redirect_pc_in),
        .freeze_pc_in   (freeze_pc_in),
        .imem_req_out   (imem_req_out),
        .imem_addr_out  (imem_addr_out),
        .imem_valid_in  (imem_valid_in),
        .imem_data_in   (imem_data_in),
        .ins_valid_out  (ins_valid_out),
        .ins_ready_in   (ins_ready_in),
        .ins_out        (ins_out),
        .npc_out        (npc_out),
        .queue_count_out(queue_count_out)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] head;
        logic [2:0]  cnt;
    } vec_t;

    pend_t pend[$];
    vec_t  tbl[20];
    int    cyc;
    int    lat;
    int    total  = 0;
    int    passed = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    endtask

    // Records this cycle's request, advances one clock, then drives the due response.
    task automatic tick();
        #1;
        if (imem_req_out) pend.push_back('{imem_addr_out, cyc + lat});
        @(posedge clock);
        #1;
        cyc++;
        if (reset) pend.delete();
        imem_valid_in = 1'b0;
        imem_data_in  = '0;
        if (pend.size() != 0 && pend[0].due == cyc) begin
            imem_valid_in = 1'b1;
            imem_data_in  = mem(pend[0].addr);
            void'(pend.pop_front());
        end
    endtask

    task automatic reset_dut(input int l);
        reset = 1'b1; redirect_in = 1'b0; freeze_pc_in = 1'b0; ins_ready_in = 1'b0;
        tick();
        tick();
        reset = 1'b0; lat = l; cyc = 0; pend.delete();
        imem_valid_in = 1'b0; imem_data_in = '0;
    endtask

    task automatic chk_head(input string nm, input logic [31:0] a);
        chk({nm, "_valid"}, 32'(ins_valid_out), 32'd1);
        chk({nm, "_ins"}, ins_out, mem(a));
        chk({nm, "_npc"}, npc_out, a + 32'd1);
    endtask

    initial begin
        int k;
        reset = 1'b1; redirect_in = 1'b0; redirect_pc_in = '0; freeze_pc_in = 1'b0;
        ins_ready_in = 1'b0; imem_valid_in = 1'b0; imem_data_in = '0; cyc = 0; lat = 1;

        tbl[0]  = '{1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0,         3'd0};
        tbl[1]  = '{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,         3'd0};
        tbl[2]  = '{1'b1, 1'b1, 32'h0,         1'b1, 32'hFFFF_FFFE, 3'd1};
        tbl[3]  = '{1'b1, 1'b1, 32'h1,         1'b1, 32'hFFFF_FFFF, 3'd1};
        tbl[4]  = '{1'b1, 1'b1, 32'h2,         1'b1, 32'h0,         3'd1};
        tbl[5]  = '{1'b0, 1'b1, 32'h3,         1'b1, 32'h1,         3'd1};
        tbl[6]  = '{1'b0, 1'b1, 32'h4,         1'b1, 32'h1,         3'd2};
        tbl[7]  = '{1'b0, 1'b0, 32'h5,         1'b1, 32'h1,         3'd3};
        for (int i = 8; i < 15; i++) tbl[i] = '{1'b0, 1'b0, 32'h5, 1'b1, 32'h1, 3'd4};
        tbl[15] = '{1'b1, 1'b0, 32'h5,         1'b1, 32'h1,         3'd4};
        tbl[16] = '{1'b1, 1'b1, 32'h5,         1'b1, 32'h2,         3'd3};
        tbl[17] = '{1'b1, 1'b1, 32'h6,         1'b1, 32'h3,         3'd2};
        tbl[18] = '{1'b1, 1'b1, 32'h7,         1'b1, 32'h4,         3'd2};
        tbl[19] = '{1'b1, 1'b1, 32'h8,         1'b1, 32'h5,         3'd2};

        // Reset state while reset is held
        tick();
        chk("rst_req", 32'(imem_req_out), 32'd0);
        chk("rst_addr", imem_addr_out, 32'd0);
        chk("rst_valid", 32'(ins_valid_out), 32'd0);
        chk("rst_count", 32'(queue_count_out), 32'd0);
        reset_dut(1);

        // Streaming, PC wrap, back-pressure fill and drain
        for (int i = 0; i < 20; i++) begin
            ins_ready_in = tbl[i].rdy;
            #1;
            chk($sformatf("t%0d_req", i), 32'(imem_req_out), 32'(tbl[i].req));
            chk($sformatf("t%0d_addr", i), imem_addr_out, tbl[i].addr);
            chk($sformatf("t%0d_valid", i), 32'(ins_valid_out), 32'(tbl[i].vld));
            chk($sformatf("t%0d_ins", i), ins_out, tbl[i].vld ? mem(tbl[i].head) : 32'h0);
            chk($sformatf("t%0d_npc", i), npc_out, tbl[i].vld ? tbl[i].head + 32'd1 : 32'h0);
            chk($sformatf("t%0d_count", i), 32'(queue_count_out), 32'(tbl[i].cnt));
            tick();
        end

        // Redirect with two requests outstanding, 3-cycle memory
        reset_dut(3);
        ins_ready_in = 1'b1;
        #1; chk("r1_c0_addr", imem_addr_out, 32'hFFFF_FFFE);
        tick();
        #1; chk("r1_c1_addr", imem_addr_out, 32'hFFFF_FFFF);
        tick();
        redirect_in = 1'b1; redirect_pc_in = 32'h40;
        #1; chk("r1_redir_req", 32'(imem_req_out), 32'd0);
        tick();
        redirect_in = 1'b0;
        #1;
        chk("r1_c3_req", 32'(imem_req_out), 32'd1);
        chk("r1_c3_addr", imem_addr_out, 32'h40);
        chk("r1_c3_count", 32'(queue_count_out), 32'd0);
        for (int i = 4; i < 7; i++) begin
            tick();
            #1; chk($sformatf("r1_c%0d_valid", i), 32'(ins_valid_out), 32'd0);
        end
        tick();
        #1;
        chk_head("r1_c7", 32'h40);
        chk("r1_c7_count", 32'(queue_count_out), 32'd1);

        // Redirect coinciding with a pop and a response
        redirect_in = 1'b1; redirect_pc_in = 32'h80;
        #1;
        chk("r2_resp_present", 32'(imem_valid_in), 32'd1);
        chk("r2_redir_req", 32'(imem_req_out), 32'd0);
        tick();
        redirect_in = 1'b0;
        #1;
        chk("r2_c8_count", 32'(queue_count_out), 32'd0);
        chk("r2_c8_valid", 32'(ins_valid_out), 32'd0);
        chk("r2_c8_addr", imem_addr_out, 32'h80);
        k = 0;
        while (!ins_valid_out && k < 10) begin
            tick(); #1; k++;
        end
        chk("r2_wait_cycles", 32'(k), 32'd4);
        chk_head("r2_first", 32'h80);
        tick();
        #1; chk_head("r2_second", 32'h81);

        // Reset mid-stream
        reset = 1'b1;
        tick();
        #1;
        chk("mr_req", 32'(imem_req_out), 32'd0);
        chk("mr_addr", imem_addr_out, 32'd0);
        chk("mr_valid", 32'(ins_valid_out), 32'd0);
        chk("mr_ins", ins_out, 32'd0);
        chk("mr_npc", npc_out, 32'd0);
        chk("mr_count", 32'(queue_count_out), 32'd0);
        reset_dut(1);
        #1;
        chk("mr_restart_req", 32'(imem_req_out), 32'd1);
        chk("mr_restart_addr", imem_addr_out, 32'hFFFF_FFFE);

        // Freeze: no issue, queued words still drain, fetch resumes at held PC
        for (int i = 0; i < 5; i++) tick();
        #1; chk("fz_full_count", 32'(queue_count_out), 32'd4);
        freeze_pc_in = 1'b1; ins_ready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("fz%0d_req", i), 32'(imem_req_out), 32'd0);
            if (i < 4) chk_head($sformatf("fz%0d", i), 32'hFFFF_FFFE + 32'(i));
            else       chk("fz_empty_valid", 32'(ins_valid_out), 32'd0);
            tick();
        end
        freeze_pc_in = 1'b0;
        #1;
        chk("fz_resume_req", 32'(imem_req_out), 32'd1);
        chk("fz_resume_addr", imem_addr_out, 32'h2);
        tick();
        tick();
        #1; chk_head("fz_resume_head", 32'h2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
